// File: rtl/instruction_encoder_if.sv
// Request/response bus of the instruction encoder: encode requests in, encoded words out.
// Carries valid/ready handshakes for both directions plus the address-counter load.
// slave modport is the encoder's view; master modport is the requester/consumer view.
interface instruction_encoder_if;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  in_format;
   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [4:0]  rd;
   logic [4:0]  rs1;
   logic [4:0]  rs2;
   logic [63:0] imm;
   logic        addr_load;
   logic [63:0] base_addr;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [63:0] out_addr;
   logic        out_err;

   modport slave (
      input  in_valid, in_format, opcode, funct3, rd, rs1, rs2, imm,
      input  addr_load, base_addr, out_ready,
      output in_ready, out_valid, out_instr, out_addr, out_err
   );

   modport master (
      output in_valid, in_format, opcode, funct3, rd, rs1, rs2, imm,
      output addr_load, base_addr, out_ready,
      input  in_ready, out_valid, out_instr, out_addr, out_err
   );
endinterface

// File: rtl/instruction_encoder.sv
// Encodes I/S/B requests into 32-bit words tagged with a running +4 word address; optional IMM_RANGE_CHECK_EN flags out-of-range immediates.
// Latency 1: an entry accepted at edge N appears on out_* after edge N when the buffer was empty.
// 2-entry buffer; in_ready drops while both entries are held and out_* stay frozen until out_ready.
module instruction_encoder (
   input  logic                  clk,
   input  logic                  rst_n,
   instruction_encoder_if.slave  bus
);

   typedef struct packed {
      logic [31:0] instr;
      logic [63:0] addr;
      logic        err;
   } entry_t;

   localparam logic [31:0] NOP_WORD = 32'h0000_0013;

   entry_t      fifo_q [2];
   logic [1:0]  count_q, count_d;
   logic        rd_ptr_q, wr_ptr_q;
   logic [63:0] addr_q, addr_d;
   logic [63:0] push_addr;
   logic [31:0] enc_instr;
   logic        enc_err;
   logic        imm_bad;
   logic        push, pop;
   entry_t      head;

`ifdef IMM_RANGE_CHECK_EN
   logic signed [63:0] imm_s;
   logic               is_fit, b_fit;
   assign imm_s   = $signed(bus.imm);
   assign is_fit  = (imm_s >= -64'sd2048) && (imm_s <= 64'sd2047);
   assign b_fit   = (imm_s >= -64'sd4096) && (imm_s <= 64'sd4094) && !bus.imm[0];
   assign imm_bad = (bus.in_format == 2'd2) ? !b_fit : !is_fit;
`else
   assign imm_bad = 1'b0;
`endif

   // Field packing per format; the word is always built from truncated immediate bits
   always_comb begin
      enc_instr = NOP_WORD;
      enc_err   = 1'b1;
      case (bus.in_format)
         2'd0: begin
            enc_instr = {bus.imm[11:0], bus.rs1, bus.funct3, bus.rd, bus.opcode};
            enc_err   = imm_bad;
         end
         2'd1: begin
            enc_instr = {bus.imm[11:5], bus.rs2, bus.rs1, bus.funct3, bus.imm[4:0], bus.opcode};
            enc_err   = imm_bad;
         end
         2'd2: begin
            enc_instr = {bus.imm[12], bus.imm[10:5], bus.rs2, bus.rs1, bus.funct3,
                         bus.imm[4:1], bus.imm[11], bus.opcode};
            enc_err   = imm_bad;
         end
         default: begin
            enc_instr = NOP_WORD;
            enc_err   = 1'b1;
         end
      endcase
   end

   // Handshakes come straight from the registered occupancy so in_ready has no input path
   assign bus.in_ready  = (count_q != 2'd2);
   assign bus.out_valid = (count_q != 2'd0);
   assign push          = bus.in_valid & bus.in_ready;
   assign pop           = bus.out_valid & bus.out_ready;
   assign head          = fifo_q[rd_ptr_q];

   assign bus.out_instr = bus.out_valid ? head.instr : 32'd0;
   assign bus.out_addr  = bus.out_valid ? head.addr  : 64'd0;
   assign bus.out_err   = bus.out_valid ? head.err   : 1'b0;

   // A same-cycle load wins over the counter so the pushed entry takes base_addr
   always_comb begin
      push_addr = bus.addr_load ? bus.base_addr : addr_q;
      addr_d    = addr_q;
      if (push)
         addr_d = push_addr + 64'd4;
      else if (bus.addr_load)
         addr_d = bus.base_addr;
      count_d = count_q + {1'b0, push} - {1'b0, pop};
   end

   // Buffer storage, pointers, occupancy and address counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fifo_q[0] <= '0;
         fifo_q[1] <= '0;
         count_q   <= 2'd0;
         rd_ptr_q  <= 1'b0;
         wr_ptr_q  <= 1'b0;
         addr_q    <= 64'd0;
      end else begin
         if (push) begin
            fifo_q[wr_ptr_q] <= '{instr: enc_instr, addr: push_addr, err: enc_err};
            wr_ptr_q         <= ~wr_ptr_q;
         end
         if (pop)
            rd_ptr_q <= ~rd_ptr_q;
         count_q <= count_d;
         addr_q  <= addr_d;
      end
   end

endmodule

// File: tb/tb_instruction_encoder.sv
// Randomized and directed checks of instruction_encoder against a queue-based reference model.
// Inputs are driven 1 time unit after the rising edge; outputs are compared on the falling edge.
// The model tracks accepted entries in a queue and the address counter as a plain integer.
module tb_instruction_encoder;

   typedef struct {
      logic [31:0] instr;
      logic [63:0] addr;
      logic        err;
   } exp_t;

   logic clk;
   logic rst_n;
   instruction_encoder_if bus ();

   instruction_encoder dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          n_cmp = 0;
   int          n_bad = 0;
   exp_t        q[$];
   logic [63:0] ctr = 64'd0;
   logic        accepted;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference encoding built from bit arithmetic on the immediate value
   function automatic void ref_encode(input logic [1:0] fmt, input logic [6:0] op,
                                      input logic [2:0] f3, input logic [4:0] rd,
                                      input logic [4:0] rs1, input logic [4:0] rs2,
                                      input logic [63:0] imm,
                                      output logic [31:0] instr, output logic err);
      longint unsigned u, w, regs;
      longint          s;
      u    = imm;
      s    = imm;
      regs = (longint'(rs1) << 15) | (longint'(f3) << 12) | longint'(op);
      err  = 1'b0;
      w    = 64'h13;
      case (fmt)
         2'd0: w = ((u & 64'hFFF) << 20) | regs | (longint'(rd) << 7);
         2'd1: w = (((u >> 5) & 64'h7F) << 25) | (longint'(rs2) << 20) | regs
                   | ((u & 64'h1F) << 7);
         2'd2: w = (((u >> 12) & 64'h1) << 31) | (((u >> 5) & 64'h3F) << 25)
                   | (longint'(rs2) << 20) | regs
                   | (((u >> 1) & 64'hF) << 8) | (((u >> 11) & 64'h1) << 7);
         default: begin
            w   = 64'h13;
            err = 1'b1;
         end
      endcase
`ifdef IMM_RANGE_CHECK_EN
      if (fmt == 2'd0 || fmt == 2'd1)
         err = (s < -2048) || (s > 2047);
      else if (fmt == 2'd2)
         err = (s < -4096) || (s > 4094) || ((u & 64'h1) != 0);
`endif
      instr = w[31:0];
   endfunction

   task automatic drive(input logic v, input logic [1:0] fmt, input logic [6:0] op,
                        input logic [2:0] f3, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [63:0] imm,
                        input logic al, input logic [63:0] base, input logic ordy);
      bus.in_valid  = v;
      bus.in_format = fmt;
      bus.opcode    = op;
      bus.funct3    = f3;
      bus.rd        = rd;
      bus.rs1       = rs1;
      bus.rs2       = rs2;
      bus.imm       = imm;
      bus.addr_load = al;
      bus.base_addr = base;
      bus.out_ready = ordy;
   endtask

   task automatic idle(input logic ordy);
      drive(1'b0, 2'd0, 7'd0, 3'd0, 5'd0, 5'd0, 5'd0, 64'd0, 1'b0, 64'd0, ordy);
   endtask

   // One clock: compare outputs with the model, then advance the model across the edge
   task automatic cycle();
      exp_t e;
      logic pop_m;
      @(negedge clk);
      chk("in_ready", bus.in_ready, (q.size() < 2));
      chk("out_valid", bus.out_valid, (q.size() > 0));
      if (q.size() > 0) begin
         chk("out_instr", bus.out_instr, q[0].instr);
         chk("out_addr", bus.out_addr, q[0].addr);
         chk("out_err", bus.out_err, q[0].err);
      end else begin
         chk("idle_instr", bus.out_instr, 64'd0);
         chk("idle_addr", bus.out_addr, 64'd0);
         chk("idle_err", bus.out_err, 64'd0);
      end
      accepted = bus.in_valid && (q.size() < 2);
      pop_m    = bus.out_ready && (q.size() > 0);
      if (pop_m) void'(q.pop_front());
      if (bus.addr_load) ctr = bus.base_addr;
      if (accepted) begin
         ref_encode(bus.in_format, bus.opcode, bus.funct3, bus.rd, bus.rs1, bus.rs2,
                    bus.imm, e.instr, e.err);
         e.addr = ctr;
         q.push_back(e);
         ctr = ctr + 64'd4;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic rand_in(input int ordy_pct);
      logic [63:0] imm, base;
      int          k;
      k = $urandom_range(0, 3);
      if (k == 0)      imm = {$urandom, $urandom};
      else if (k == 1) imm = 64'($signed($urandom_range(0, 10000)) - 5000);
      else             imm = 64'($signed($urandom_range(0, 8200)) - 4100);
      base = ($urandom_range(0, 3) == 0) ? 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 15))
                                         : {$urandom, $urandom};
      drive($urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)), 7'($urandom),
            3'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), imm,
            $urandom_range(0, 9) == 0, base, $urandom_range(0, 99) < ordy_pct);
   endtask

   initial begin
      logic [31:0] w;
      int          guard;
      rst_n = 1'b0;
      idle(1'b1);
      #3;
      chk("rst_out_valid", bus.out_valid, 64'd0);
      chk("rst_in_ready", bus.in_ready, 64'd1);
      chk("rst_out_addr", bus.out_addr, 64'd0);
      #9 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Basic I encode, first address is 0
      drive(1'b1, 2'd0, 7'h13, 3'd0, 5'd1, 5'd0, 5'd0, 64'd5, 1'b0, 64'd0, 1'b1);
      cycle();
      chk("v_i_instr", bus.out_instr, 32'h0050_0093);
      chk("v_i_addr", bus.out_addr, 64'd0);
      chk("v_i_err", bus.out_err, 64'd0);

      // Address load coincident with a push, then S
      drive(1'b1, 2'd0, 7'h03, 3'd2, 5'd2, 5'd1, 5'd0, 64'd8, 1'b1, 64'h1000, 1'b1);
      cycle();
      chk("v_ld_instr", bus.out_instr, 32'h0080_A103);
      chk("v_ld_addr", bus.out_addr, 64'h1000);
      drive(1'b1, 2'd1, 7'h23, 3'd2, 5'd0, 5'd1, 5'd2, 64'd12, 1'b0, 64'd0, 1'b1);
      cycle();
      chk("v_s_instr", bus.out_instr, 32'h0020_A623);
      chk("v_s_addr", bus.out_addr, 64'h1004);

      // Negative branch offset
      drive(1'b1, 2'd2, 7'h63, 3'd0, 5'd0, 5'd1, 5'd2, -64'sd8, 1'b0, 64'd0, 1'b1);
      cycle();
      chk("v_b_instr", bus.out_instr, 32'hFE20_8CE3);
      chk("v_b_err", bus.out_err, 64'd0);

      // Immediate just above the I range, then the illegal format
      drive(1'b1, 2'd0, 7'h13, 3'd0, 5'd3, 5'd4, 5'd0, 64'd2048, 1'b0, 64'd0, 1'b1);
      cycle();
      w = bus.out_instr;
      chk("v_imm_hi", w[31:20], 64'h800);
`ifdef IMM_RANGE_CHECK_EN
      chk("v_imm_err", bus.out_err, 64'd1);
`else
      chk("v_imm_err", bus.out_err, 64'd0);
`endif
      drive(1'b1, 2'd3, 7'h7F, 3'd7, 5'd31, 5'd31, 5'd31, 64'hDEAD_BEEF, 1'b0, 64'd0, 1'b1);
      cycle();
      chk("v_ill_instr", bus.out_instr, 32'h0000_0013);
      chk("v_ill_err", bus.out_err, 64'd1);

      // Counter wrap through 2^64
      drive(1'b1, 2'd0, 7'h13, 3'd0, 5'd1, 5'd1, 5'd0, 64'd1, 1'b1,
            64'hFFFF_FFFF_FFFF_FFFC, 1'b1);
      cycle();
      drive(1'b1, 2'd0, 7'h13, 3'd0, 5'd1, 5'd1, 5'd0, 64'd2, 1'b0, 64'd0, 1'b1);
      cycle();
      chk("v_wrap_addr", bus.out_addr, 64'd0);
      idle(1'b1);
      cycle();

      // Back-pressure: two accepted, third held until space frees
      drive(1'b1, 2'd0, 7'h13, 3'd0, 5'd5, 5'd0, 5'd0, 64'd10, 1'b0, 64'd0, 1'b0);
      cycle();
      drive(1'b1, 2'd1, 7'h23, 3'd0, 5'd0, 5'd6, 5'd7, 64'd20, 1'b0, 64'd0, 1'b0);
      cycle();
      drive(1'b1, 2'd2, 7'h63, 3'd1, 5'd0, 5'd8, 5'd9, 64'd32, 1'b0, 64'd0, 1'b0);
      cycle();
      chk("bp_third_held", accepted, 64'd0);
      chk("bp_in_ready", bus.in_ready, 64'd0);
      bus.out_ready = 1'b1;
      guard = 0;
      accepted = 1'b0;
      while (!accepted && guard < 10) begin
         cycle();
         guard++;
      end
      chk("bp_third_taken", accepted, 64'd1);
      idle(1'b1);
      for (int i = 0; i < 3; i++) cycle();

      // Randomized traffic
      for (int i = 0; i < 1500; i++) begin
         rand_in((i < 750) ? 40 : 85);
         cycle();
      end
      idle(1'b1);
      for (int i = 0; i < 3; i++) cycle();

      // Reset with two entries buffered
      drive(1'b1, 2'd0, 7'h13, 3'd0, 5'd1, 5'd2, 5'd0, 64'd3, 1'b1, 64'h5000, 1'b0);
      cycle();
      drive(1'b1, 2'd0, 7'h13, 3'd0, 5'd1, 5'd2, 5'd0, 64'd4, 1'b0, 64'd0, 1'b0);
      cycle();
      chk("mr_full", bus.in_ready, 64'd0);
      #2 rst_n = 1'b0;
      #1;
      chk("mr_out_valid", bus.out_valid, 64'd0);
      chk("mr_in_ready", bus.in_ready, 64'd1);
      chk("mr_out_instr", bus.out_instr, 64'd0);
      q.delete();
      ctr = 64'd0;
      idle(1'b1);
      #13 rst_n = 1'b1;
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) cycle();
      drive(1'b1, 2'd0, 7'h13, 3'd0, 5'd1, 5'd0, 5'd0, 64'd7, 1'b0, 64'd0, 1'b1);
      cycle();
      chk("mr_addr_restart", bus.out_addr, 64'd0);
      idle(1'b1);
      for (int i = 0; i < 2; i++) cycle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/instruction_encoder.md
INSTRUCTION_ENCODER -- requirements
Module: instruction_encoder

Interface
REQ-001 SHALL provide ports: clk (in, 1, rising-edge clock); rst_n (in, 1, asynchronous active-low reset).
REQ-002 SHALL provide ports: in_valid (in, 1, request valid); in_ready (out, 1, entry accepted when in_valid&in_ready at clk edge).
REQ-003 SHALL provide ports: in_format (in, 2, 0=I/load, 1=S/store, 2=B/branch, 3=illegal); opcode (in, 7); funct3 (in, 3); rd, rs1, rs2 (in, 5 each).
REQ-004 SHALL provide port imm (in, 64, two's-complement immediate, byte offset for B).
REQ-005 SHALL provide ports: addr_load (in, 1, load write address); base_addr (in, 64, value loaded).
REQ-006 SHALL provide ports: out_valid (out, 1); out_ready (in, 1); out_instr (out, 32, encoded word); out_addr (out, 64, word address); out_err (out, 1, encoding error flag).

Function
REQ-007 SHALL encode I: {imm[11:0], rs1, funct3, rd, opcode}.
REQ-008 SHALL encode S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}.
REQ-009 SHALL encode B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}.
REQ-010 SHALL encode format 3 as 0x00000013 (NOP) with err=1, regardless of other inputs.
REQ-011 SHALL buffer encoded entries {instr, addr, err} in a 2-entry FIFO; in_ready = (count<2), combinational from registered count only.
REQ-012 SHALL present an entry accepted at edge N on out_* after edge N (latency 1) when FIFO was empty.
REQ-013 SHALL hold out_instr/out_addr/out_err stable while out_valid=1 and out_ready=0.
REQ-014 SHALL pop on out_valid&out_ready; simultaneous push and pop at count=1 SHALL leave count=1 in order.
REQ-015 SHALL tag each accepted entry with the write-address counter value, then increment counter by 4, wrapping modulo 2^64.
REQ-016 SHALL, on addr_load=1, load counter with base_addr; if a push occurs in the same cycle, that entry SHALL take base_addr and counter SHALL become base_addr+4.
REQ-017 SHALL drive out_instr/out_addr/out_err to 0 when out_valid=0.

Reset
REQ-018 SHALL, on rst_n low, asynchronously clear FIFO (count=0, out_valid=0, out_instr=0, out_addr=0, out_err=0) and counter=0; in_ready=1 after reset.
REQ-019 SHALL discard any in-flight or buffered entries on reset mid-operation; no entry SHALL appear after rst_n rises until a new push.

Configuration
REQ-020 SHALL, with IMM_RANGE_CHECK_EN defined, set err=1 when imm is outside [-2048,2047] for I/S, outside [-4096,4094] for B, or imm[0]=1 for B; word still encoded from truncated bits.
REQ-021 SHALL, without IMM_RANGE_CHECK_EN, silently truncate imm and set err only for format 3.

Verification
REQ-022 Reset then push I op=0x13 f3=0 rd=1 rs1=0 imm=5, out_ready=1 -> next cycle out_valid=1, out_instr=0x00500093, out_addr=0, out_err=0.
REQ-023 addr_load base=0x1000 with push I op=0x03 f3=2 rd=2 rs1=1 imm=8, then S op=0x23 f3=2 rs1=1 rs2=2 imm=12 -> 0x0080A103 @0x1000, 0x0020A623 @0x1004.
REQ-024 Push B op=0x63 f3=0 rs1=1 rs2=2 imm=-8 -> out_instr=0xFE208CE3, out_err=0.
REQ-025 out_ready=0, push 3 back-to-back -> in_ready low after 2 accepted, third held; raise out_ready -> all 3 emitted in order, addresses +4 each.
REQ-026 With IMM_RANGE_CHECK_EN, push I imm=2048 -> out_err=1, out_instr[31:20]=0x800; format 3 -> 0x00000013, out_err=1; without macro first case out_err=0.
REQ-027 2 entries buffered, assert rst_n low mid-cycle -> out_valid=0 immediately, counter=0, no stale entries after release.
